// File: rtl/hamming_dec_engine.sv
// Hamming SECDED decoder stage: reads 16-bit codewords from data memory,
// corrects/flags them and writes back 11-bit messages with error flags.
module hamming_dec_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic [CNT_W-1:0]  n_single,
  output logic [CNT_W-1:0]  n_double
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;
  localparam logic [2:0] S_WR_HI = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  idx;
  logic [7:0]        lo_q;
  logic [7:0]        out_hi;
  logic [7:0]        out_lo;

  logic [15:0]       w;
  logic [3:0]        syn;
  logic              par;
  logic [10:0]       data;
  logic [1:0]        flag;
  logic [ADDR_W-1:0] off;

  // Syndrome is the XOR of the positions of all set bits 1..15.
  always_comb begin
    int j;
    w    = {mem_rd_data, lo_q};
    syn  = 4'd0;
    par  = ^w;
    data = 11'd0;
    flag = 2'b00;
    j    = 0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) syn = syn ^ 4'(k);
    end
    for (int k = 3; k < 16; k++) begin
      if (k != 4 && k != 8) begin
        data[j] = w[k] ^ (par && (syn == 4'(k)));
        j = j + 1;
      end
    end
    if (par) flag = 2'b01;
    else if (syn != 4'd0) flag = 2'b10;
  end

  // Sequencer: five cycles per word, counters saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      lo_q     <= 8'd0;
      out_hi   <= 8'd0;
      out_lo   <= 8'd0;
      n_single <= '0;
      n_double <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= '0;
            n_single <= '0;
            n_double <= '0;
            state    <= S_RD_LO;
          end
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: begin
          lo_q  <= mem_rd_data;
          state <= S_CAP;
        end
        S_CAP: begin
          out_hi <= {flag, 3'b000, data[10:8]};
          out_lo <= data[7:0];
          if (flag[0] && n_single != '1)
            n_single <= n_single + 1'b1;
          if (flag[1] && n_double != '1)
            n_double <= n_double + 1'b1;
          state <= S_WR_LO;
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= S_DONE;
          else state <= S_RD_LO;
        end
        S_DONE: begin
          if (start) begin
            done     <= 1'b0;
            idx      <= '0;
            n_single <= '0;
            n_double <= '0;
            state    <= S_RD_LO;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign off  = ADDR_W'({idx, 1'b0});
  assign busy = (state != S_IDLE) && (state != S_DONE);

  // Memory port drive; everything idles at zero outside its state.
  always_comb begin
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = 8'd0;
    mem_wr_en   = 1'b0;
    case (state)
      S_RD_LO: mem_rd_addr = ADDR_W'(SRC_BASE) + off;
      S_RD_HI: mem_rd_addr = ADDR_W'(SRC_BASE) + off + ADDR_W'(1);
      S_WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = ADDR_W'(DST_BASE) + off;
        mem_wr_data = out_lo;
      end
      S_WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = ADDR_W'(DST_BASE) + off + ADDR_W'(1);
        mem_wr_data = out_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: table of codewords with hand-derived
// outputs, plus latency, restart and mid-run reset sequences.
module tb_hamming_dec_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic [3:0] n_single;
  logic [3:0] n_double;

  logic [7:0] src  [256];
  logic [7:0] dmem [256];
  logic       clr;
  int         wr_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] enc;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vt [15];

  always #5 clk = ~clk;

  hamming_dec_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .n_single   (n_single),
    .n_double   (n_double)
  );

  // Byte memory: encoded source bytes live in src, results in dmem.
  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 256; a++) dmem[a] <= 8'hA5;
      wr_count <= 0;
    end else if (mem_wr_en) begin
      dmem[mem_wr_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
    end
    mem_rd_data <= (mem_rd_addr >= 8'd30) ? src[mem_rd_addr]
                                          : dmem[mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run(input bit repulse, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_low_after_start", done, 0);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 10) chk("busy_mid", busy, 1);
      start = repulse && (cyc == 20);
    end
    start = 1'b0;
    chk("latency", cyc, 76);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_lo%0d", tag, i), dmem[2*i], vt[i].lo);
      chk($sformatf("%s_hi%0d", tag, i), dmem[2*i+1], vt[i].hi);
    end
    chk({tag, "_n_single"}, n_single, 6);
    chk({tag, "_n_double"}, n_double, 2);
    chk({tag, "_writes"}, wr_count, 30);
  endtask

  initial begin
    int cyc;
    vt[0]  = '{16'h0000, 8'h00, 8'h00};
    vt[1]  = '{16'h0020, 8'h40, 8'h00};
    vt[2]  = '{16'h0001, 8'h40, 8'h00};
    vt[3]  = '{16'hFFFF, 8'h07, 8'hFF};
    vt[4]  = '{16'h0003, 8'h80, 8'h00};
    vt[5]  = '{16'h000F, 8'h00, 8'h01};
    vt[6]  = '{16'h0007, 8'h40, 8'h01};
    vt[7]  = '{16'h8117, 8'h04, 8'h00};
    vt[8]  = '{16'h0115, 8'h80, 8'h00};
    vt[9]  = '{16'h0303, 8'h00, 8'h10};
    vt[10] = '{16'h1303, 8'h40, 8'h10};
    vt[11] = '{16'hFFFE, 8'h47, 8'hFF};
    vt[12] = '{16'h7FFF, 8'h47, 8'hFF};
    vt[13] = '{16'h0000, 8'h00, 8'h00};
    vt[14] = '{16'hF0F0, 8'h07, 8'h8E};

    for (int a = 0; a < 256; a++) src[a] = 8'h00;
    for (int i = 0; i < 15; i++) begin
      src[30+2*i] = vt[i].enc[7:0];
      src[31+2*i] = vt[i].enc[15:8];
    end

    reset = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    clear_mem();
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_n_single", n_single, 0);
    chk("rst_n_double", n_double, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rd_addr", mem_rd_addr, 0);

    // First run, with a stray start pulse while busy.
    run(1'b1, cyc);
    check_out("run1");
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);

    // Restart from DONE: results must be reproduced.
    clear_mem();
    chk("done_before_rerun", done, 1);
    run(1'b0, cyc);
    check_out("run2");

    // Reset during word 7's low-byte write.
    clear_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_wr_en && mem_wr_addr == 8'd14) && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("w7_wr_lo_cycle", cyc, 38);
    reset = 1'b0;
    #1;
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr_en", mem_wr_en, 0);
    chk("arst_wr_addr", mem_wr_addr, 0);
    chk("arst_wr_data", mem_wr_data, 0);
    chk("arst_rd_addr", mem_rd_addr, 0);
    chk("arst_n_single", n_single, 0);
    chk("arst_n_double", n_double, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("part_lo%0d", i), dmem[2*i], vt[i].lo);
      chk($sformatf("part_hi%0d", i), dmem[2*i+1], vt[i].hi);
    end
    for (int a = 14; a < 30; a++)
      chk($sformatf("untouched%0d", a), dmem[a], 8'hA5);
    chk("part_writes", wr_count, 14);

    // Fresh run after the abort.
    clear_mem();
    run(1'b0, cyc);
    check_out("run3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
